// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the peripheral-to-memory DMA controller:
//   - controller state encoding
//   - config-port register addresses
//   - CTRL register bit positions
// -----------------------------------------------------------------------------
package dma_pkg;

  // Controller state: idle, moving words, finished (interrupt pending)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  // Config-port register map (address 3 is reserved and ignored)
  localparam logic [1:0] CFG_BASE  = 2'd0;
  localparam logic [1:0] CFG_COUNT = 2'd1;
  localparam logic [1:0] CFG_CTRL  = 2'd2;

  // CTRL register bits
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/dma_fifo.sv
// -----------------------------------------------------------------------------
// dma_fifo
// Small synchronous FIFO that buffers peripheral words until the DMA wins the
// memory port. Registered storage with no bypass: a word pushed in one cycle
// is visible at the head in the next cycle at the earliest.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   flush_i  in   drop all contents (has priority over push/pop)
//   push_i   in   write data_i (ignored when full)
//   data_i   in   word to buffer
//   pop_i    in   remove head (ignored when empty)
//   data_o   out  head word
//   full_o   out  FIFO_DEPTH words buffered
//   empty_o  out  no words buffered
// -----------------------------------------------------------------------------
module dma_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == {(PTR_W + 1){1'b0}});
  assign data_o  = mem_q[rd_ptr_q];

  // Qualify push/pop with occupancy and compute next pointers/count
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {(PTR_W + 1){1'b0}};
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s && !do_pop_s) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!do_push_s && do_pop_s) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {(PTR_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; only the slot being pushed changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// -----------------------------------------------------------------------------
// dma_ctrl
// Peripheral-to-memory DMA controller. The CPU programs BASE and COUNT, then
// writes CTRL.start. Peripheral words are buffered in dma_fifo and written to
// consecutive word addresses whenever the DMA wins the shared memory port.
// The CPU normally has priority; after STARVE_LIM consecutive denied cycles
// the DMA takes the port and the CPU is stalled. Completion holds irq until
// ack (or a new start).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cfg_we/addr/wdata  config write port (BASE, COUNT, CTRL)
//   nextTransaction    peripheral word strobe, periph_data its payload
//   periph_rdy         buffer can accept a word this cycle
//   cpu_mem_req        CPU memory stage wants the port this cycle
//   cpu_stall          CPU denied the port this cycle
//   en/memAddr/memDataOut  DMA side of the memory write port
//   busy, err, irq     status; ack clears irq
// -----------------------------------------------------------------------------
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              nextTransaction,
  input  logic [DATA_W-1:0] periph_data,
  output logic              periph_rdy,
  input  logic              cpu_mem_req,
  output logic              cpu_stall,
  output logic              en,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  output logic              busy,
  output logic              err,
  output logic              irq,
  input  logic              ack
);

  localparam int STARVE_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM_C = STARVE_W'(STARVE_LIM);
  localparam logic [DATA_W-1:0]   WORD_BYTES   = DATA_W'(4);
  localparam logic [CNT_W-1:0]    CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);

  dma_state_e          state_q, state_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_q, err_d;

  logic              ctrl_wr_s;
  logic              start_s;
  logic              abort_s;
  logic              push_s;
  logic              dma_req_s;
  logic              force_s;
  logic              cpu_wins_s;
  logic              dma_wins_s;
  logic              flush_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;

  dma_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_s),
    .push_i  (push_s),
    .data_i  (periph_data),
    .pop_i   (dma_wins_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Decode CTRL writes, peripheral acceptance and port arbitration
  always_comb begin
    ctrl_wr_s  = cfg_we && (cfg_addr == CFG_CTRL);
    start_s    = ctrl_wr_s && cfg_wdata[CTRL_START];
    abort_s    = ctrl_wr_s && cfg_wdata[CTRL_ABORT];
    // acc_q caps acceptance so no more than COUNT words are ever buffered
    periph_rdy = (state_q == XFER) && !fifo_full_s && (acc_q < count_q);
    push_s     = nextTransaction && periph_rdy;
    // An abort silences the write port in the very cycle it is written
    dma_req_s  = (state_q == XFER) && !fifo_empty_s && !abort_s;
    force_s    = (starve_q >= STARVE_LIM_C);
    cpu_wins_s = cpu_mem_req && !force_s;
    dma_wins_s = dma_req_s && !cpu_wins_s;
    en         = dma_wins_s;
    cpu_stall  = cpu_mem_req && dma_wins_s;
    busy       = (state_q == XFER);
    irq        = (state_q == DONE);
    err        = err_q;
    if (dma_wins_s) begin
      memAddr    = addr_q;
      memDataOut = fifo_head_s;
    end else begin
      memAddr    = {DATA_W{1'b0}};
      memDataOut = {DATA_W{1'b0}};
    end
  end

  // Next-state logic for the FSM, config registers and transfer counters
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    starve_d = starve_q;
    err_d    = err_q;
    flush_s  = 1'b0;

    // BASE/COUNT are frozen while a transfer is running
    if (cfg_we && (state_q != XFER)) begin
      case (cfg_addr)
        CFG_BASE:  base_d  = {cfg_wdata[DATA_W-1:2], 2'b00};
        CFG_COUNT: count_d = cfg_wdata[CNT_W-1:0];
        default:   base_d  = base_q;
      endcase
    end else begin
      base_d  = base_q;
      count_d = count_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_s && !abort_s) begin
          if (count_q != CNT_ZERO) begin
            state_d  = XFER;
            addr_d   = base_q;
            rem_d    = count_q;
            acc_d    = CNT_ZERO;
            starve_d = {STARVE_W{1'b0}};
            flush_s  = 1'b1;
            err_d    = 1'b0;
          end else begin
            // Leaving DONE on any start also drops the pending interrupt
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if ((state_q == DONE) && ack) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
        // Peripheral strobes outside a transfer are dropped and flagged
        if (nextTransaction) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
      end
      XFER: begin
        if (push_s) begin
          acc_d = acc_q + CNT_ONE;
        end else begin
          acc_d = acc_q;
        end
        if (dma_wins_s) begin
          addr_d   = addr_q + WORD_BYTES;
          rem_d    = rem_q - CNT_ONE;
          starve_d = {STARVE_W{1'b0}};
          if (rem_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = XFER;
          end
        end else if (dma_req_s) begin
          // Denied by the CPU; force_s is low here so this never overshoots
          starve_d = starve_q + 1'b1;
        end else begin
          starve_d = starve_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything else and never raises irq
    if (abort_s) begin
      state_d  = IDLE;
      flush_s  = 1'b1;
      starve_d = {STARVE_W{1'b0}};
    end else begin
      flush_s = flush_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= {DATA_W{1'b0}};
      count_q  <= CNT_ZERO;
      addr_q   <= {DATA_W{1'b0}};
      rem_q    <= CNT_ZERO;
      acc_q    <= CNT_ZERO;
      starve_q <= {STARVE_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_ctrl
// Scoreboard bench for dma_ctrl: every accepted peripheral word pushes its
// expected {address, data} pair; each en cycle pops and compares.
// -----------------------------------------------------------------------------
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        nextTransaction;
  logic [31:0] periph_data;
  logic        periph_rdy;
  logic        cpu_mem_req;
  logic        cpu_stall;
  logic        en;
  logic [31:0] memAddr;
  logic [31:0] memDataOut;
  logic        busy;
  logic        err;
  logic        irq;
  logic        ack;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          en_cyc_q[$];
  wr_t         mon_w;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_addr;
  int          acc_n;
  int          first_drop_acc;
  int          k;

  dma_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .nextTransaction (nextTransaction),
    .periph_data     (periph_data),
    .periph_rdy      (periph_rdy),
    .cpu_mem_req     (cpu_mem_req),
    .cpu_stall       (cpu_stall),
    .en              (en),
    .memAddr         (memAddr),
    .memDataOut      (memDataOut),
    .busy            (busy),
    .err             (err),
    .irq             (irq),
    .ack             (ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every write must match the next expected word
  always @(negedge clk) begin
    if (!rst && en) begin
      en_cyc_q.push_back(cyc);
      check_eq("stall_on_en", {31'd0, cpu_stall}, {31'd0, cpu_mem_req});
      if (exp_q.size() == 0) begin
        check_eq("unexpected_en", {31'd0, en}, 32'd0);
      end else begin
        mon_w = exp_q.pop_front();
        check_eq("wr_addr", memAddr, mon_w.addr);
        check_eq("wr_data", memDataOut, mon_w.data);
      end
    end else if (!rst && cpu_stall) begin
      check_eq("stall_no_en", {31'd0, cpu_stall}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] cnt);
    cfg_wr(2'd0, base);
    cfg_wr(2'd1, cnt);
    cfg_wr(2'd2, 32'd1);
    exp_addr = base & 32'hFFFF_FFFC;
    acc_n = 0;
  endtask

  // Drive one peripheral strobe; only words the DUT can accept are expected
  task automatic send_word(input logic [31:0] d);
    nextTransaction = 1'b1;
    periph_data = d;
    if (periph_rdy) begin
      exp_q.push_back('{addr: exp_addr, data: d});
      exp_addr = exp_addr + 32'd4;
      acc_n++;
    end
    tick();
    nextTransaction = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int maxc);
    for (int i = 0; i < maxc && !irq; i++) tick();
    check_eq(tag, {31'd0, irq}, 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_en"}, {31'd0, en}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_irq"}, {31'd0, irq}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    check_eq({tag, "_rdy"}, {31'd0, periph_rdy}, 32'd0);
    check_eq({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    check_eq({tag, "_addr"}, memAddr, 32'd0);
    check_eq({tag, "_data"}, memDataOut, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    nextTransaction = 1'b0; periph_data = 32'd0; cpu_mem_req = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: free port, three words written back to back
    start_xfer(32'h100, 32'd3);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    en_cyc_q.delete();
    k = cyc;
    send_word(32'hA); send_word(32'hB); send_word(32'hC);
    wait_irq("t1_irq", 20);
    check_eq("t1_busy_done", {31'd0, busy}, 32'd0);
    check_eq("t1_writes", en_cyc_q.size(), 32'd3);
    if (en_cyc_q.size() > 0) check_eq("t1_latency", en_cyc_q[0], k + 1);
    check_eq("t1_sb_empty", exp_q.size(), 32'd0);
    pulse_ack();
    check_eq("t1_irq_ack", {31'd0, irq}, 32'd0);

    // 2: CPU hogs the port, DMA forces through every 4th cycle
    cpu_mem_req = 1'b1;
    start_xfer(32'h200, 32'd3);
    en_cyc_q.delete();
    k = cyc;
    send_word(32'h21); send_word(32'h22); send_word(32'h23);
    wait_irq("t2_irq", 40);
    check_eq("t2_writes", en_cyc_q.size(), 32'd3);
    if (en_cyc_q.size() == 3) begin
      check_eq("t2_first_en", en_cyc_q[0], k + 4);
      check_eq("t2_second_en", en_cyc_q[1], k + 8);
      check_eq("t2_third_en", en_cyc_q[2], k + 12);
    end
    cpu_mem_req = 1'b0;
    pulse_ack();

    // 3: zero-count start flags err; valid start clears it; idle strobe sets it
    cfg_wr(2'd1, 32'd0);
    cfg_wr(2'd2, 32'd1);
    check_eq("t3_err_set", {31'd0, err}, 32'd1);
    check_eq("t3_not_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check_eq("t3_still_idle", {31'd0, busy}, 32'd0);
    start_xfer(32'h303, 32'd1);
    check_eq("t3_err_clr", {31'd0, err}, 32'd0);
    send_word(32'h33);
    wait_irq("t3_irq", 20);
    pulse_ack();
    check_eq("t3_idle_rdy", {31'd0, periph_rdy}, 32'd0);
    send_word(32'h99);
    check_eq("t3_idle_strobe_err", {31'd0, err}, 32'd1);

    // 4: burst of 8 into a 4-deep buffer with the CPU hogging
    cpu_mem_req = 1'b1;
    start_xfer(32'h400, 32'd8);
    check_eq("t4_err_clr", {31'd0, err}, 32'd0);
    first_drop_acc = -1;
    for (int i = 0; i < 64 && acc_n < 8; i++) begin
      if (!periph_rdy && first_drop_acc < 0) first_drop_acc = acc_n;
      send_word(32'h4000 + i);
    end
    check_eq("t4_accepted", acc_n, 32'd8);
    check_eq("t4_drop_at", first_drop_acc, 32'd4);
    wait_irq("t4_irq", 100);
    check_eq("t4_sb_empty", exp_q.size(), 32'd0);
    check_eq("t4_err", {31'd0, err}, 32'd0);
    cpu_mem_req = 1'b0;
    pulse_ack();

    // 5: abort with a word still buffered, then restart from a new BASE
    start_xfer(32'h500, 32'd5);
    en_cyc_q.delete();
    send_word(32'h51); send_word(32'h52); send_word(32'h53);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'd2;
    @(negedge clk);
    check_eq("t5_abort_en", {31'd0, en}, 32'd0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check_eq("t5_written", en_cyc_q.size(), 32'd2);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_en", {31'd0, en}, 32'd0);
    check_eq("t5_irq", {31'd0, irq}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    check_eq("t5_irq_later", {31'd0, irq}, 32'd0);
    start_xfer(32'h600, 32'd1);
    send_word(32'h66);
    wait_irq("t5_restart_irq", 20);
    check_eq("t5_sb_empty", exp_q.size(), 32'd0);
    pulse_ack();

    // 6: reset with two words buffered
    cpu_mem_req = 1'b1;
    start_xfer(32'h700, 32'd4);
    send_word(32'h71); send_word(32'h72);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    exp_q.delete();
    en_cyc_q.delete();
    tick(); tick();
    rst = 1'b0;
    cpu_mem_req = 1'b0;
    repeat (10) tick();
    check_eq("t6_no_en", en_cyc_q.size(), 32'd0);
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    start_xfer(32'h800, 32'd1);
    send_word(32'h88);
    wait_irq("t6_recover_irq", 20);
    check_eq("t6_sb_empty", exp_q.size(), 32'd0);
    pulse_ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
